// File: rtl/alu_ctrl_stage.sv
// -----------------------------------------------------------------------------
// alu_ctrl_stage
//
// ID/EX pipeline stage for the ALU. Decodes the main-decoder ALU-op class and
// the R-type funct field into a 3-bit ALU select, chooses operand B, and
// registers select, operands and a valid bit into EX under hazard-unit
// stall (hold) and flush (bubble) control. Also keeps a wrap-around count of
// valid instructions issued to EX and a sticky illegal-funct flag.
//
// Parameters
//   DATA_W      operand width
//   CNT_W       issued-instruction counter width
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous reset, active-low
//   id_valid    ID holds a real instruction
//   id_alu_op   ALU-op class: 00 add, 01 sub, 10 R-type (use funct), 11 slt
//   id_funct    instruction[5:0]
//   id_rs_data  register-file read A
//   id_rt_data  register-file read B
//   id_imm      sign-extended immediate
//   id_b_sel    1 selects id_imm as B, 0 selects id_rt_data
//   stall       hold EX register contents
//   flush       load a bubble into EX (overrides stall)
//   err_clr     clear sticky illegal flag
//   ex_valid    EX holds a real instruction
//   ex_alu_ctrl ALU select: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
//   ex_a        ALU operand A
//   ex_b        ALU operand B
//   ex_illegal  instruction in EX had an unsupported funct
//   err_illegal sticky illegal-funct flag
//   issue_cnt   valid instructions issued to EX, modulo 2^CNT_W
// -----------------------------------------------------------------------------
module alu_ctrl_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [1:0]        id_alu_op,
    input  logic [5:0]        id_funct,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_b_sel,
    input  logic              stall,
    input  logic              flush,
    input  logic              err_clr,
    output logic              ex_valid,
    output logic [2:0]        ex_alu_ctrl,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic              ex_illegal,
    output logic              err_illegal,
    output logic [CNT_W-1:0]  issue_cnt
);

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_sel_e;

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_SUB   = 2'b01,
        OP_RTYPE = 2'b10,
        OP_SLT   = 2'b11
    } alu_op_e;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    alu_sel_e          dec_sel;
    logic              dec_illegal;
    logic [DATA_W-1:0] dec_b;
    logic              load_en;
    logic              err_set;

    // ------------------------------------------------------------------
    // Decode: ALU select and illegal-funct detection
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latch.
        dec_sel     = ALU_ADD;
        dec_illegal = 1'b0;
        case (alu_op_e'(id_alu_op))
            OP_ADD: dec_sel = ALU_ADD;
            OP_SUB: dec_sel = ALU_SUB;
            OP_SLT: dec_sel = ALU_SLT;
            OP_RTYPE: begin
                case (id_funct)
                    FN_ADD:  dec_sel = ALU_ADD;
                    FN_SUB:  dec_sel = ALU_SUB;
                    FN_AND:  dec_sel = ALU_AND;
                    FN_OR:   dec_sel = ALU_OR;
                    FN_SLT:  dec_sel = ALU_SLT;
                    // Unsupported funct still issues as ADD, but is flagged.
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_sel = ALU_ADD;
        endcase
    end

    assign dec_b = id_b_sel ? id_imm : id_rt_data;

    // A normal load happens only when neither flush nor stall is asserted.
    assign load_en = !flush && !stall;
    assign err_set = load_en && id_valid && dec_illegal;

    // ------------------------------------------------------------------
    // EX register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples pre-edge values regardless of statement order.
        if (!rst) begin
            ex_valid    <= 1'b0;
            ex_alu_ctrl <= ALU_AND;
            ex_a        <= '0;
            ex_b        <= '0;
            ex_illegal  <= 1'b0;
        end else if (flush) begin
            ex_valid    <= 1'b0;
            ex_alu_ctrl <= ALU_AND;
            ex_a        <= '0;
            ex_b        <= '0;
            ex_illegal  <= 1'b0;
        end else if (!stall) begin
            // Operands and select load even for a non-valid slot; only the
            // illegal marker is qualified so bubbles never report errors.
            ex_valid    <= id_valid;
            ex_alu_ctrl <= dec_sel;
            ex_a        <= id_rs_data;
            ex_b        <= dec_b;
            ex_illegal  <= dec_illegal && id_valid;
        end
    end

    // ------------------------------------------------------------------
    // Issued-instruction counter (wraps naturally at 2^CNT_W)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_cnt <= '0;
        end else if (load_en && id_valid) begin
            issue_cnt <= issue_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Sticky illegal flag: set has priority over clear on the same edge
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_illegal <= 1'b0;
        end else if (err_set) begin
            err_illegal <= 1'b1;
        end else if (err_clr) begin
            err_illegal <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_ctrl_stage
//
// Directed self-checking bench for alu_ctrl_stage. The DUT is built with
// CNT_W=4 so the issue counter wrap is reachable with a short sequence.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_alu_ctrl_stage;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst;
    logic              id_valid;
    logic [1:0]        id_alu_op;
    logic [5:0]        id_funct;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm;
    logic              id_b_sel;
    logic              stall;
    logic              flush;
    logic              err_clr;
    logic              ex_valid;
    logic [2:0]        ex_alu_ctrl;
    logic [DATA_W-1:0] ex_a;
    logic [DATA_W-1:0] ex_b;
    logic              ex_illegal;
    logic              err_illegal;
    logic [CNT_W-1:0]  issue_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    alu_ctrl_stage #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_alu_op  (id_alu_op),
        .id_funct   (id_funct),
        .id_rs_data (id_rs_data),
        .id_rt_data (id_rt_data),
        .id_imm     (id_imm),
        .id_b_sel   (id_b_sel),
        .stall      (stall),
        .flush      (flush),
        .err_clr    (err_clr),
        .ex_valid   (ex_valid),
        .ex_alu_ctrl(ex_alu_ctrl),
        .ex_a       (ex_a),
        .ex_b       (ex_b),
        .ex_illegal (ex_illegal),
        .err_illegal(err_illegal),
        .issue_cnt  (issue_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Compare every EX-side output against hand-computed values.
    task automatic expect_ex(input string tag, input logic v, input logic [2:0] ctrl,
                             input logic [31:0] a, input logic [31:0] b, input logic ill,
                             input logic err, input logic [3:0] cnt);
        check({tag, ".valid"}, 32'(ex_valid), 32'(v));
        check({tag, ".ctrl"},  32'(ex_alu_ctrl), 32'(ctrl));
        check({tag, ".a"},     ex_a, a);
        check({tag, ".b"},     ex_b, b);
        check({tag, ".ill"},   32'(ex_illegal), 32'(ill));
        check({tag, ".err"},   32'(err_illegal), 32'(err));
        check({tag, ".cnt"},   32'(issue_cnt), 32'(cnt));
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] imm, input logic bsel);
        id_valid   = v;
        id_alu_op  = op;
        id_funct   = fn;
        id_rs_data = rs;
        id_rt_data = rt;
        id_imm     = imm;
        id_b_sel   = bsel;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between edges and release it on a falling edge.
    task automatic pulse_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    logic [5:0] fn_tab   [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [2:0] ctrl_tab [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        err_clr = 1'b0;
        drive(1'b1, 2'(($urandom)), 6'($urandom), $urandom, $urandom, $urandom, 1'($urandom));

        // Asynchronous reset before the first rising edge (at t=5).
        #2 rst = 1'b0;
        #1;
        expect_ex("rst_async", 1'b0, 3'b000, 0, 0, 1'b0, 1'b0, 4'd0);
        tick();
        tick();
        expect_ex("rst_held", 1'b0, 3'b000, 0, 0, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        rst = 1'b1;

        // First load after reset release.
        drive(1'b1, 2'b00, 6'h00, 32'd5, 32'd99, 32'd7, 1'b1);
        tick();
        expect_ex("first_load", 1'b1, 3'b010, 32'd5, 32'd7, 1'b0, 1'b0, 4'd1);

        // R-type funct sweep, B from rt.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'b10, fn_tab[i], 32'(100 + i), 32'(200 + i), 32'd0, 1'b0);
            tick();
            expect_ex($sformatf("funct_%0h", fn_tab[i]), 1'b1, ctrl_tab[i],
                      32'(100 + i), 32'(200 + i), 1'b0, 1'b0, 4'(2 + i));
        end
        drive(1'b1, 2'b10, 6'h08, 32'd11, 32'd12, 32'd0, 1'b0);
        tick();
        expect_ex("funct_illegal", 1'b1, 3'b010, 32'd11, 32'd12, 1'b1, 1'b1, 4'd7);

        // Sticky flag: clear with a legal load, then clear racing an illegal load.
        err_clr = 1'b1;
        drive(1'b1, 2'b11, 6'h08, 32'd1, 32'd2, 32'd3, 1'b1);
        tick();
        expect_ex("err_clear", 1'b1, 3'b111, 32'd1, 32'd3, 1'b0, 1'b0, 4'd8);
        drive(1'b1, 2'b10, 6'h3F, 32'd4, 32'd5, 32'd6, 1'b0);
        tick();
        expect_ex("err_set_wins", 1'b1, 3'b010, 32'd4, 32'd5, 1'b1, 1'b1, 4'd9);
        err_clr = 1'b0;

        // Stall: load rt=9, then hold for 3 edges while ID keeps changing.
        drive(1'b1, 2'b01, 6'h00, 32'd8, 32'd9, 32'd77, 1'b0);
        tick();
        expect_ex("pre_stall", 1'b1, 3'b110, 32'd8, 32'd9, 1'b0, 1'b1, 4'd10);
        stall = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, 2'b11, 6'h08, 32'(50 + k), 32'(60 + k), 32'd0, 1'b0);
            tick();
            expect_ex($sformatf("stall_%0d", k), 1'b1, 3'b110, 32'd8, 32'd9, 1'b0, 1'b1, 4'd10);
        end
        flush = 1'b1;
        tick();
        expect_ex("stall_flush", 1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b1, 4'd10);
        stall = 1'b0;
        flush = 1'b0;

        // Invalid slot with illegal funct: operands load, no illegal, no count,
        // and err_clr is free to clear the sticky flag.
        err_clr = 1'b1;
        drive(1'b0, 2'b10, 6'h08, 32'd3, 32'd4, 32'd0, 1'b0);
        tick();
        expect_ex("invalid_load", 1'b0, 3'b010, 32'd3, 32'd4, 1'b0, 1'b0, 4'd10);
        err_clr = 1'b0;

        // Counter wrap from a clean start: 17 valid issues at CNT_W=4 -> 1.
        pulse_reset();
        expect_ex("rst_before_wrap", 1'b0, 3'b000, 0, 0, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 2'b00, 6'h00, 32'(i), 32'd0, 32'd1, 1'b1);
            tick();
        end
        expect_ex("wrap", 1'b1, 3'b010, 32'd16, 32'd1, 1'b0, 1'b0, 4'd1);
        drive(1'b0, 2'b00, 6'h00, 32'd9, 32'd0, 32'd2, 1'b1);
        tick();
        tick();
        expect_ex("wrap_invalid_hold", 1'b0, 3'b010, 32'd9, 32'd2, 1'b0, 1'b0, 4'd1);

        // Mid-stream reset with ex_valid=1 and issue_cnt=5.
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'b10, 6'h08, 32'd21, 32'd22, 32'd0, 1'b0);
            tick();
        end
        expect_ex("pre_midrst", 1'b1, 3'b010, 32'd21, 32'd22, 1'b1, 1'b1, 4'd5);
        #2 rst = 1'b0;
        #1;
        expect_ex("midrst_async", 1'b0, 3'b000, 0, 0, 1'b0, 1'b0, 4'd0);
        tick();
        expect_ex("midrst_held", 1'b0, 3'b000, 0, 0, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 2'b01, 6'h00, 32'd2, 32'd3, 32'd0, 1'b0);
        tick();
        expect_ex("post_midrst", 1'b1, 3'b110, 32'd2, 32'd3, 1'b0, 1'b0, 4'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_stage.md
# alu_ctrl_stage

ID/EX pipeline stage that produces the 3-bit ALU operation select and both ALU operands for the execute stage. It decodes the main-decoder ALU-op class and the R-type funct field into the ALU select encoding. It registers the select, operands and a valid bit into EX, with stall (hold) and flush (bubble) control from the hazard unit. It also keeps a wrap-around count of instructions issued to EX and a sticky illegal-funct flag.

## Interface
- DATA_W, 32, operand width
- CNT_W, 16, issued-instruction counter width

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- id_valid  in  1  ID holds a real instruction
- id_alu_op  in  2  ALU-op class: 00 add, 01 sub, 10 R-type (use funct), 11 slt
- id_funct  in  6  instruction[5:0]
- id_rs_data  in  DATA_W  register-file read A
- id_rt_data  in  DATA_W  register-file read B
- id_imm  in  DATA_W  sign-extended immediate
- id_b_sel  in  1  1 selects id_imm as B, 0 selects id_rt_data
- stall  in  1  hold EX register contents
- flush  in  1  load a bubble into EX
- err_clr  in  1  clear sticky illegal flag
- ex_valid  out  1  EX holds a real instruction
- ex_alu_ctrl  out  3  ALU select: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- ex_a  out  DATA_W  ALU operand A
- ex_b  out  DATA_W  ALU operand B
- ex_illegal  out  1  instruction in EX had an unsupported funct
- err_illegal  out  1  sticky illegal-funct flag
- issue_cnt  out  CNT_W  valid instructions issued to EX, modulo 2^CNT_W

## Operation
- Combinational decode of ALU select:
  - id_alu_op 00 -> 010
  - id_alu_op 01 -> 110
  - id_alu_op 11 -> 111
  - id_alu_op 10, by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - Any other funct under 10 -> select 010 with illegal=1. Illegal is 0 in every other case.
- B operand is id_imm when id_b_sel=1, otherwise id_rt_data. A is always id_rs_data.
- EX register update each rising edge, in priority order:
  - flush=1: ex_valid=0, ex_alu_ctrl=000, ex_a=0, ex_b=0, ex_illegal=0. Flush overrides stall.
  - else stall=1: all EX outputs hold their values.
  - else: load ex_valid=id_valid, the decoded select, A, B, and ex_illegal = illegal & id_valid.
- A load with id_valid=0 still loads operands and select. ex_illegal is 0 in that case.
- issue_cnt increments by 1 on every edge that performs a normal load with id_valid=1. It wraps from all-ones to 0 and holds otherwise.
- err_illegal is set on any edge that loads ex_illegal=1. Otherwise err_clr=1 clears it. If set and clear occur on the same edge, set wins.

## Timing
- Reset (rst low, asynchronous): every output is 0 immediately and stays 0 while rst is low. ex_alu_ctrl=000 during reset.
- First capture occurs on the first rising edge after rst goes high.
- Latency: an ID value present before edge N appears on EX outputs after edge N, i.e. 1 cycle.
- Decode is purely combinational ahead of the register. There is no combinational path from any input to any output.
- Stall of k cycles holds EX for exactly k edges. issue_cnt does not advance while stalled.
- Flush during stall produces a bubble on that edge. The held instruction is discarded and is not counted again.
- Reset asserted mid-stream discards the EX contents, the counter and the sticky flag.

## Test plan
- Reset: drive rst=0 with random inputs -> all outputs 0, asynchronously, without a clock edge. Release rst, then load id_alu_op=00, rs=5, imm=7, b_sel=1 -> after 1 edge: ex_valid=1, ctrl=010, a=5, b=7, issue_cnt=1.
- Funct sweep: id_alu_op=10, funct 20h/22h/24h/25h/2Ah -> ctrl 010/110/000/001/111 with ex_illegal=0. funct 08h -> ctrl 010, ex_illegal=1, err_illegal=1.
- Stall/flush: load rt=9, b_sel=0, then stall 3 cycles while ID changes -> EX holds b=9 and issue_cnt is unchanged. Assert stall and flush together -> ex_valid=0, ctrl=000, a=b=0.
- Sticky flag: with err_illegal=1, pulse err_clr with no new illegal -> err_illegal=0. Pulse err_clr on the same edge as an illegal load -> err_illegal stays 1.
- Counter wrap: with CNT_W=4, issue 17 valid instructions -> issue_cnt=1. Loads with id_valid=0 leave the count unchanged and keep ex_illegal=0.
- Reset mid-stream: rst low between edges while ex_valid=1 and issue_cnt=5 -> all outputs 0 immediately, and they stay 0 through the next edge while rst is low.
